alu_div_ctrl: RTL and testbench
===============================

# alu_div_ctrl

Request/response sequencer that sits directly upstream of the unsigned iterative divider (ALU_DIV) and consumes its quotient/remainder. It accepts signed or unsigned DIV/REM requests over a valid/ready handshake, converts operands to magnitudes and holds them stable at the divider, waits for its `done`, applies RISC-V sign and corner-case rules, and returns one 32-bit result per request.

## Interface
- `WIDTH`, 32: operand/result width; must match the divider.
- `ARM_CYCLES`, 2: cycles `div_done` is ignored after new operands are driven, covering the divider's operand-change detect and counter reload.
- `clk`  in  1: rising-edge clock, shared with the divider.
- `rst_n`  in  1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE.
- `req_op`  in  2: 0=DIV, 1=DIVU, 2=REM, 3=REMU.
- `req_a`, `req_b`  in  WIDTH: dividend, divisor.
- `rsp_valid`  out  1: result valid; held until accepted.
- `rsp_ready`  in  1: consumer accepts.
- `rsp_data`  out  WIDTH: quotient or remainder, per op.
- `rsp_dbz`  out  1: divisor was zero.
- `div_dividend`, `div_divisor`  out  WIDTH: registered operands to the divider.
- `div_done`  in  1: divider done.
- `div_quotient`, `div_remainder`  in  WIDTH: divider results.

## Operation
- FSM states: IDLE, ARM, WAIT, FIX, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op, sign bits, and zero-divisor flag.
  - Signed ops: drive |a|, |b| as unsigned magnitudes. |−2^31| = 0x8000_0000.
  - Go to ARM.
- ARM: count ARM_CYCLES with `div_done` ignored, then go to WAIT.
- WAIT: on `div_done`=1, capture `div_quotient` and `div_remainder`, then go to FIX.
- FIX: compute the result.
  - Signed quotient: negated iff sign(a)≠sign(b) and b≠0.
  - Signed remainder: takes sign(a).
  - Unsigned ops: no fixup.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into `rsp_data`.
  - Go to RESP.
- RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Required corner results:
  - b=0: quotient = all-ones; remainder = a; `rsp_dbz`=1.
  - DIV −2^31/−1: quotient = 0x8000_0000, remainder = 0.
  - Both fall out of magnitude + fixup arithmetic with no special path.
- `div_dividend` and `div_divisor` hold their values from IDLE-accept until the next accept; they never change during ARM or WAIT.

## Timing
- Reset values: `req_ready`=0 while `rst_n` is low, 1 in IDLE after reset. `rsp_valid`=0, `rsp_data`=0, `rsp_dbz`=0, `div_dividend`=0, `div_divisor`=0. FSM in IDLE.
- Latency: accept → `rsp_valid` = 1 + ARM_CYCLES + (divider latency) + 1 cycles. With a 32-step divider and defaults, this is 36 cycles minimum.
- No overlap: `req_ready`=0 from accept until the cycle after RESP handshake. Back-to-back accept therefore occurs at the earliest one cycle after `rsp_valid&&rsp_ready`.
- `rsp_*` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset mid-operation: immediate return to IDLE; the in-flight result is discarded and no response is issued.
- `div_done` asserted during ARM is ignored, because it is stale from the previous operation.

## Configuration
- `ALU_DIV_FASTPATH_EN` defined:
  - In IDLE, b=0 or signed (−2^31, −1) skips ARM/WAIT and goes straight to FIX with precomputed results.
  - Latency for these cases is 2 cycles to `rsp_valid`.
  - Divider operands are not updated for fast-path requests.
- Undefined: every request goes through the divider; results are identical and only latency differs.

## Structure
- Shared package `alu_div_pkg` holds:
  - `div_op_e` enum: DIV, DIVU, REM, REMU.
  - `div_state_e`.
  - `WIDTH_DEFAULT`=32 and `ARM_CYCLES_DEFAULT`=2.
- Sub-module `alu_div_signfix`: combinational magnitude/negate and result-select logic. FSM and registers stay in the top.

## Test plan
- DIVU 100/7 → `rsp_data`=14. REMU 100/7 → 2. `rsp_dbz`=0. Latency = 36 cycles.
- DIV −100/7 → 0xFFFF_FFF2 (−14). REM −100/7 → 0xFFFF_FFFE (−2). REM 100/−7 → 2.
- DIV 5/0 → 0xFFFF_FFFF with `rsp_dbz`=1. REMU 5/0 → 5. With the macro defined, `rsp_valid` rises 2 cycles after accept.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000. REM of the same operands → 0.
- Hold `rsp_ready`=0 for 10 cycles, then pulse it → `rsp_data` stable throughout, `req_ready` rises the next cycle, and a second request is accepted correctly.
- Deassert `rst_n` during WAIT → all outputs return to reset values immediately, no response is issued, and the next request completes correctly.

Source files
------------

// File: rtl/alu_div_pkg.sv
// Shared types and defaults for the divider request sequencer (alu_div_ctrl).
package alu_div_pkg;

  localparam int WIDTH_DEFAULT      = 32;
  localparam int ARM_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    FIX  = 3'd3,
    RESP = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/alu_div_ctrl_if.sv
// Request, response and divider-side signals of alu_div_ctrl.
// slave = the sequencer; master = requester, consumer and divider around it.
interface alu_div_ctrl_if #(parameter int WIDTH = alu_div_pkg::WIDTH_DEFAULT);
  import alu_div_pkg::*;

  logic             req_valid;
  logic             req_ready;
  div_op_e          req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_dbz;

  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
           div_done, div_quotient, div_remainder,
    output req_ready, rsp_valid, rsp_data, rsp_dbz,
           div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
           div_done, div_quotient, div_remainder,
    input  req_ready, rsp_valid, rsp_data, rsp_dbz,
           div_dividend, div_divisor
  );

endinterface

// File: rtl/alu_div_signfix.sv
// Operand magnitudes for the unsigned divider and RISC-V sign fixup / result select.
module alu_div_signfix
  import alu_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  div_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] mag_a_o,
  output logic [WIDTH-1:0] mag_b_o,
  input  div_op_e          fix_op_i,
  input  logic             sign_a_i,
  input  logic             sign_b_i,
  input  logic             b_zero_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] rem_i,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  logic             req_signed;
  logic             fix_signed;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Negating -2^(WIDTH-1) wraps to itself, which is exactly the unsigned magnitude.
  always_comb begin
    req_signed = op_is_signed(op_i);
    mag_a_o    = (req_signed && a_i[WIDTH-1]) ? negate(a_i) : a_i;
    mag_b_o    = (req_signed && b_i[WIDTH-1]) ? negate(b_i) : b_i;
  end

  always_comb begin
    fix_signed = op_is_signed(fix_op_i);
    neg_q      = fix_signed && (sign_a_i ^ sign_b_i) && !b_zero_i;
    neg_r      = fix_signed && sign_a_i;
    q_fix      = neg_q ? negate(quo_i) : quo_i;
    r_fix      = neg_r ? negate(rem_i) : rem_i;
    result_o   = op_is_rem(fix_op_i) ? r_fix : q_fix;
  end

endmodule

// File: rtl/alu_div_ctrl.sv
// Request/response sequencer wrapped around the unsigned iterative divider.
// ALU_DIV_FASTPATH_EN: resolve b=0 and signed MIN/-1 locally without the divider.
module alu_div_ctrl
  import alu_div_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_div_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | ready for a request; latch op/signs, drive magnitudes
  // ARM   | divider reloading; its done is stale and ignored
  // WAIT  | waiting for div_done, then capture quotient/remainder
  // FIX   | apply sign fixup and select the result
  // RESP  | rsp_valid held until rsp_ready

  localparam int CW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [CW-1:0] ARM_LOAD = CW'(ARM_CYCLES - 1);

  div_state_e       state_q,    state_d;
  div_op_e          op_q,       op_d;
  logic             sign_a_q,   sign_a_d;
  logic             sign_b_q,   sign_b_d;
  logic             dbz_q,      dbz_d;
  logic [WIDTH-1:0] dvd_q,      dvd_d;
  logic [WIDTH-1:0] dvs_q,      dvs_d;
  logic [WIDTH-1:0] quo_q,      quo_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [CW-1:0]    arm_cnt_q,  arm_cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_dbz_q,  rsp_dbz_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] result;
  logic             req_b_zero;
  logic             take_fast;

  alu_div_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op_i     (bus.req_op),
    .a_i      (bus.req_a),
    .b_i      (bus.req_b),
    .mag_a_o  (mag_a),
    .mag_b_o  (mag_b),
    .fix_op_i (op_q),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .b_zero_i (dbz_q),
    .quo_i    (quo_q),
    .rem_i    (rem_q),
    .result_o (result)
  );

  assign req_b_zero = (bus.req_b == '0);

`ifdef ALU_DIV_FASTPATH_EN
  assign take_fast = req_b_zero ||
                     (op_is_signed(bus.req_op) &&
                      (bus.req_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.req_b == '1));
`else
  assign take_fast = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dbz_d      = dbz_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    arm_cnt_d  = arm_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_dbz_d  = rsp_dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          sign_a_d = op_is_signed(bus.req_op) & bus.req_a[WIDTH-1];
          sign_b_d = op_is_signed(bus.req_op) & bus.req_b[WIDTH-1];
          dbz_d    = req_b_zero;
          if (take_fast) begin
            // Same raw results the divider would return, so FIX needs no special case.
            quo_d   = req_b_zero ? '1 : mag_a;
            rem_d   = req_b_zero ? mag_a : '0;
            state_d = FIX;
          end else begin
            dvd_d     = mag_a;
            dvs_d     = mag_b;
            arm_cnt_d = ARM_LOAD;
            state_d   = ARM;
          end
        end
      end
      ARM: begin
        if (arm_cnt_q == '0) state_d = WAIT;
        else                 arm_cnt_d = arm_cnt_q - CW'(1);
      end
      WAIT: begin
        if (bus.div_done) begin
          quo_d   = bus.div_quotient;
          rem_d   = bus.div_remainder;
          state_d = FIX;
        end
      end
      FIX: begin
        rsp_data_d = result;
        rsp_dbz_d  = dbz_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= DIVU;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dbz_q      <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      arm_cnt_q  <= '0;
      rsp_data_q <= '0;
      rsp_dbz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      dbz_q      <= dbz_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      arm_cnt_q  <= arm_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_dbz_q  <= rsp_dbz_d;
    end
  end

  // Gated by rst_n so the port does not advertise ready while held in reset.
  assign bus.req_ready    = rst_n && (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_dbz      = rsp_dbz_q;
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Randomized self-checking bench for alu_div_ctrl with a behavioural divider and result model.
`timescale 1ns/1ps
module tb_alu_div_ctrl;
  import alu_div_pkg::*;

  localparam int W       = 32;
  localparam int DIV_LAT = 33;
  localparam logic [W-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [W-1:0] ALL_ONE = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_div_ctrl_if #(.WIDTH(W)) bus ();

  alu_div_ctrl #(.WIDTH(W), .ARM_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_dvd = '0;
  logic [W-1:0] exp_dvs = '0;

  // Divider model: restarts on every accept, keeps the previous done (stale) for
  // one cycle, then raises done with a/b computed from the operands it is driven.
  int dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt              <= 0;
      bus.div_done      <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
    end else if (bus.req_valid && bus.req_ready) begin
      dcnt <= DIV_LAT;
    end else if (dcnt > 1) begin
      dcnt         <= dcnt - 1;
      bus.div_done <= 1'b0;
    end else if (dcnt == 1) begin
      dcnt         <= 0;
      bus.div_done <= 1'b1;
      if (bus.div_divisor == '0) begin
        bus.div_quotient  <= ALL_ONE;
        bus.div_remainder <= bus.div_dividend;
      end else begin
        bus.div_quotient  <= bus.div_dividend / bus.div_divisor;
        bus.div_remainder <= bus.div_dividend % bus.div_divisor;
      end
    end
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input div_op_e op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    int sa, sb;
    logic [W-1:0] r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      DIVU: r = (b == 0) ? ALL_ONE : a / b;
      REMU: r = (b == 0) ? a : a % b;
      DIV: begin
        if (b == 0)                            r = ALL_ONE;
        else if (a == INT_MIN && b == ALL_ONE) r = INT_MIN;
        else                                   r = sa / sb;
      end
      default: begin
        if (b == 0)                            r = a;
        else if (a == INT_MIN && b == ALL_ONE) r = '0;
        else                                   r = sa % sb;
      end
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] magnitude(input div_op_e op, input logic [W-1:0] v);
    if ((op == DIV || op == REM) && v[W-1]) return 32'h0 - v;
    return v;
  endfunction

  task automatic do_req(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] exp_data, first_data;
    logic         exp_dbz, fast, stable, busy_ok, hold_ok;
    int           lat, budget, exp_lat;
    exp_data = ref_result(op, a, b);
    exp_dbz  = (b == 0);
`ifdef ALU_DIV_FASTPATH_EN
    fast = (b == 0) || ((op == DIV || op == REM) && a == INT_MIN && b == ALL_ONE);
`else
    fast = 1'b0;
`endif
    exp_lat = fast ? 2 : 36;

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    budget = 0;
    while (!bus.req_ready && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    check_val($sformatf("%s:accept", tag), {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    if (!fast) begin
      exp_dvd = magnitude(op, a);
      exp_dvs = magnitude(op, b);
    end
    @(negedge clk);
    lat           = 1;
    bus.req_valid = 1'b0;
    bus.req_op    = div_op_e'($urandom_range(0, 3));
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    stable  = 1'b1;
    busy_ok = 1'b1;
    while (!bus.rsp_valid && lat < 100) begin
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.div_dividend !== exp_dvd || bus.div_divisor !== exp_dvs) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_val($sformatf("%s:latency", tag), lat, exp_lat);
    check_val($sformatf("%s:data", tag), bus.rsp_data, exp_data);
    check_val($sformatf("%s:dbz", tag), {31'b0, bus.rsp_dbz}, {31'b0, exp_dbz});
    check_val($sformatf("%s:operands", tag), {31'b0, stable}, 32'd1);
    check_val($sformatf("%s:busy_ready", tag), {31'b0, busy_ok}, 32'd1);

    first_data = bus.rsp_data;
    hold_ok    = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== first_data || bus.rsp_dbz !== exp_dbz)
        hold_ok = 1'b0;
    end
    if (hold > 0) check_val($sformatf("%s:hold", tag), {31'b0, hold_ok}, 32'd1);

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_val($sformatf("%s:ready_after", tag), {31'b0, bus.req_ready}, 32'd1);
    check_val($sformatf("%s:valid_after", tag), {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic    saw;
    div_op_e rop;
    logic [W-1:0] ra, rb;
    int      sel;

    bus.req_valid = 1'b0;
    bus.req_op    = DIVU;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    #1;
    check_val("rst:req_ready", {31'b0, bus.req_ready}, 32'd0);
    check_val("rst:rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_val("rst:rsp_data", bus.rsp_data, 32'd0);
    check_val("rst:rsp_dbz", {31'b0, bus.rsp_dbz}, 32'd0);
    check_val("rst:dividend", bus.div_dividend, 32'd0);
    check_val("rst:divisor", bus.div_divisor, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle:req_ready", {31'b0, bus.req_ready}, 32'd1);

    do_req(DIVU, 32'd100, 32'd7, 0, "divu_100_7");
    do_req(REMU, 32'd100, 32'd7, 0, "remu_100_7");
    do_req(DIV,  32'hFFFF_FF9C, 32'd7, 1, "div_m100_7");
    do_req(REM,  32'hFFFF_FF9C, 32'd7, 0, "rem_m100_7");
    do_req(REM,  32'd100, 32'hFFFF_FFF9, 0, "rem_100_m7");
    do_req(DIV,  32'd5, 32'd0, 0, "div_5_0");
    do_req(REMU, 32'd5, 32'd0, 2, "remu_5_0");
    do_req(REM,  32'hFFFF_FFFB, 32'd0, 0, "rem_m5_0");
    do_req(DIV,  INT_MIN, ALL_ONE, 0, "div_ovf");
    do_req(REM,  INT_MIN, ALL_ONE, 0, "rem_ovf");
    do_req(DIVU, 32'd1000, 32'd3, 10, "hold10");
    do_req(DIV,  32'd1000, 32'hFFFF_FFFD, 0, "after_hold");

    // Reset while the divider is running.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = DIV;
    bus.req_a     = 32'd12345;
    bus.req_b     = 32'd17;
    saw = 1'b0;
    for (int i = 0; i < 60 && !saw; i++) begin
      if (bus.req_ready) saw = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid:rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check_val("rst_mid:req_ready", {31'b0, bus.req_ready}, 32'd0);
    check_val("rst_mid:rsp_data", bus.rsp_data, 32'd0);
    check_val("rst_mid:dividend", bus.div_dividend, 32'd0);
    check_val("rst_mid:divisor", bus.div_divisor, 32'd0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_dvd = '0;
    exp_dvs = '0;
    saw     = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    check_val("rst_mid:no_rsp", {31'b0, saw}, 32'd0);
    do_req(REM, 32'd12345, 32'd17, 0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      rop = div_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = '0;
        1: begin
          rop = ($urandom_range(0, 1) == 0) ? DIV : REM;
          ra  = INT_MIN;
          rb  = ALL_ONE;
        end
        2: begin
          ra = $urandom_range(0, 200);
          rb = $urandom_range(1, 20);
        end
        3: begin
          ra = 32'h0 - $urandom_range(0, 500);
          rb = ($urandom_range(0, 1) == 0) ? 32'h0 - $urandom_range(1, 30) : $urandom_range(1, 30);
        end
        4: rb = $urandom_range(1, 255);
        default: ;
      endcase
      do_req(rop, ra, rb, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
